// File: rtl/fft_64p_frame_sink.sv
// fft_64p_frame_sink
// Ping-pong frame buffer behind an FFT core. The write side has no backpressure:
// whole frames are captured into one of two banks. The read side streams each
// full bank out in bin order over a valid/ready handshake. A frame that arrives
// while both banks are full is counted and dropped as a whole.
//
// Handshake: a beat transfers on a rising edge where dout_valid && dout_ready.
// While dout_valid is high and dout_ready is low, the beat (data, index, sof, eof)
// is held unchanged. dout_valid never drops mid-frame once a beat has been offered.
module fft_64p_frame_sink #(
    parameter int DATA_WIDTH = 17,
    parameter int FRAME_LEN  = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        din_re,
    input  logic [DATA_WIDTH-1:0]        din_im,
    input  logic                         din_valid,
    output logic [DATA_WIDTH-1:0]        dout_re,
    output logic [DATA_WIDTH-1:0]        dout_im,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic [$clog2(FRAME_LEN)-1:0] dout_index,
    output logic                         dout_sof,
    output logic                         dout_eof,
    output logic [15:0]                  frame_cnt,
    output logic                         overflow,
    output logic [7:0]                   drop_cnt,
    output logic                         dbg_rd_state
);

    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } rd_state_t;

    // Two banks of complex samples
    logic [DATA_WIDTH-1:0] r_mem_re [2][FRAME_LEN];
    logic [DATA_WIDTH-1:0] r_mem_im [2][FRAME_LEN];

    // Write side state
    logic             r_wr_bank;
    logic [IDX_W-1:0] r_wr_idx;
    logic             r_wr_drop;
    logic [1:0]       r_full;
    logic             r_overflow;
    logic [7:0]       r_drop_cnt;

    // Read side state
    rd_state_t             r_rd_state;
    logic                  r_rd_bank;
    logic [IDX_W-1:0]      r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_dout_re;
    logic [DATA_WIDTH-1:0] r_dout_im;
    logic                  r_dout_valid;
    logic [IDX_W-1:0]      r_dout_index;
    logic                  r_dout_sof;
    logic                  r_dout_eof;
    logic [15:0]           r_frame_cnt;

    logic       w_rd_release;
    logic [1:0] w_full_eff;
    logic       w_frame_drop;
    logic       w_wr_en;

    // The last beat of a frame leaving the output register frees its bank
    assign w_rd_release = (r_rd_state == ST_STREAM) && r_dout_valid && dout_ready && r_dout_eof;

    // Full flags as seen by the writer after this edge's release, so a release and
    // a frame start on the same edge see an empty bank
    always_comb begin
        w_full_eff = r_full;
        if (w_rd_release) begin
            w_full_eff[r_rd_bank] = 1'b0;
        end
    end

    // Drop decision is taken on sample 0 and then held for the rest of the frame
    assign w_frame_drop = (r_wr_idx == '0) ? w_full_eff[r_wr_bank] : r_wr_drop;
    assign w_wr_en      = din_valid && !w_frame_drop;

    // Write-side index, bank selection, full flags and drop accounting
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_bank  <= 1'b0;
            r_wr_idx   <= '0;
            r_wr_drop  <= 1'b0;
            r_full     <= 2'b00;
            r_overflow <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else begin
            r_full <= w_full_eff;
            if (din_valid) begin
                r_wr_drop <= w_frame_drop;
                if ((r_wr_idx == '0) && w_frame_drop) begin
                    r_overflow <= 1'b1;
                    if (r_drop_cnt != 8'hFF) begin
                        r_drop_cnt <= r_drop_cnt + 8'd1;
                    end
                end
                if (r_wr_idx == LAST_IDX) begin
                    r_wr_idx <= '0;
                    if (!w_frame_drop) begin
                        r_full[r_wr_bank] <= 1'b1;
                        r_wr_bank         <= ~r_wr_bank;
                    end
                end else begin
                    r_wr_idx <= r_wr_idx + 1'b1;
                end
            end
        end
    end

    // Sample storage; contents need no reset
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_re[r_wr_bank][r_wr_idx] <= din_re;
            r_mem_im[r_wr_bank][r_wr_idx] <= din_im;
        end
    end

    // Read FSM: wait for a full bank, then stream it out through the output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state   <= ST_IDLE;
            r_rd_bank    <= 1'b0;
            r_rd_ptr     <= '0;
            r_dout_re    <= '0;
            r_dout_im    <= '0;
            r_dout_valid <= 1'b0;
            r_dout_index <= '0;
            r_dout_sof   <= 1'b0;
            r_dout_eof   <= 1'b0;
            r_frame_cnt  <= 16'd0;
        end else begin
            case (r_rd_state)
                ST_IDLE: begin
                    if (r_full[r_rd_bank]) begin
                        r_rd_state <= ST_STREAM;
                        r_rd_ptr   <= '0;
                    end
                end
                ST_STREAM: begin
                    if (w_rd_release) begin
                        r_dout_valid <= 1'b0;
                        r_dout_sof   <= 1'b0;
                        r_dout_eof   <= 1'b0;
                        r_rd_bank    <= ~r_rd_bank;
                        r_rd_ptr     <= '0;
                        r_frame_cnt  <= r_frame_cnt + 16'd1;
                        r_rd_state   <= r_full[~r_rd_bank] ? ST_STREAM : ST_IDLE;
                    end else if (!r_dout_valid || dout_ready) begin
                        r_dout_re    <= r_mem_re[r_rd_bank][r_rd_ptr];
                        r_dout_im    <= r_mem_im[r_rd_bank][r_rd_ptr];
                        r_dout_index <= r_rd_ptr;
                        r_dout_sof   <= (r_rd_ptr == '0);
                        r_dout_eof   <= (r_rd_ptr == LAST_IDX);
                        r_dout_valid <= 1'b1;
                        r_rd_ptr     <= (r_rd_ptr == LAST_IDX) ? '0 : r_rd_ptr + 1'b1;
                    end
                end
                default: r_rd_state <= ST_IDLE;
            endcase
        end
    end

    assign dout_re      = r_dout_re;
    assign dout_im      = r_dout_im;
    assign dout_valid   = r_dout_valid;
    assign dout_index   = r_dout_index;
    assign dout_sof     = r_dout_sof;
    assign dout_eof     = r_dout_eof;
    assign frame_cnt    = r_frame_cnt;
    assign overflow     = r_overflow;
    assign drop_cnt     = r_drop_cnt;
    assign dbg_rd_state = (r_rd_state == ST_STREAM);

endmodule

// File: tb/tb_fft_64p_frame_sink.sv
// Bench for fft_64p_frame_sink: frame-level reference model (occupancy count plus
// a queue of expected samples) compared against the DUT every cycle.
module tb_fft_64p_frame_sink;

    localparam int W = 17;
    localparam int N = 64;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din_re = '0;
    logic [W-1:0] din_im = '0;
    logic         din_valid = 1'b0;
    logic [W-1:0] dout_re, dout_im;
    logic         dout_valid;
    logic         dout_ready = 1'b0;
    logic [5:0]   dout_index;
    logic         dout_sof, dout_eof;
    logic [15:0]  frame_cnt;
    logic         overflow;
    logic [7:0]   drop_cnt;
    logic         dbg_rd_state;

    always #5 clk = ~clk;

    fft_64p_frame_sink #(.DATA_WIDTH(W), .FRAME_LEN(N)) dut (
        .clk(clk), .rst(rst),
        .din_re(din_re), .din_im(din_im), .din_valid(din_valid),
        .dout_re(dout_re), .dout_im(dout_im), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout_index(dout_index),
        .dout_sof(dout_sof), .dout_eof(dout_eof),
        .frame_cnt(frame_cnt), .overflow(overflow), .drop_cnt(drop_cnt),
        .dbg_rd_state(dbg_rd_state)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- ready driver ----------------
    int ready_mode  = 0;  // 0 constant, 1 pattern 1,0,0,1, 2 random
    bit ready_const = 1'b0;
    int pat_i = 0;

    always begin
        @(posedge clk); #1;
        case (ready_mode)
            0: dout_ready = ready_const;
            1: begin
                dout_ready = (pat_i == 0) || (pat_i == 3);
                pat_i = (pat_i + 1) % 4;
            end
            default: dout_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // ---------------- reference model / scoreboard ----------------
    // Frames that completed capture wait in exp_q (one entry per sample).
    // m_occ = frames captured but not yet fully delivered; a new frame is
    // dropped exactly when both banks are occupied at its first sample.
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] cur_frame[N];
    int m_idx = 0, m_beat = 0, m_occ = 0, m_drop_cnt = 0, m_frame_cnt = 0;
    bit m_drop = 0, m_ovf = 0;
    int lat_req = 0, lat_seen = 0, lat_c63 = 0;
    bit lat_wait = 0;
    bit prev_stall = 0, prev_mid = 0;

    // Sampled on the falling edge: inputs here are what the next rising edge sees.
    always @(negedge clk) begin
        logic [2*W-1:0] e;
        cyc++;
        if (rst) begin
            exp_q.delete();
            m_idx = 0; m_beat = 0; m_occ = 0; m_drop = 0; m_ovf = 0;
            m_drop_cnt = 0; m_frame_cnt = 0;
            lat_wait = 0; prev_stall = 0; prev_mid = 0;
        end else begin
            chk("frame_cnt", frame_cnt, m_frame_cnt);
            chk("overflow", overflow, m_ovf);
            chk("drop_cnt", drop_cnt, m_drop_cnt);
            if (prev_stall) chk("hold_valid", dout_valid, 1);
            if (prev_mid)   chk("no_bubble", dout_valid, 1);
            // Sample 63 accepted at the edge after negedge c63; index 0 must be
            // visible after edge c63+2, i.e. first seen at negedge c63+3.
            if (lat_wait && dout_valid) begin
                chk("latency", cyc - lat_c63, 3);
                lat_wait = 0;
            end
            prev_stall = 0;
            prev_mid   = 0;
            if (dout_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 1, 0);
                end else begin
                    e = exp_q[0];
                    chk("dout_re", dout_re, e[2*W-1:W]);
                    chk("dout_im", dout_im, e[W-1:0]);
                    chk("dout_index", dout_index, m_beat);
                    chk("dout_sof", dout_sof, m_beat == 0);
                    chk("dout_eof", dout_eof, m_beat == N - 1);
                    chk("dbg_state", dbg_rd_state, 1);
                    if (dout_ready) begin
                        void'(exp_q.pop_front());
                        m_beat++;
                        if (m_beat == N) begin
                            m_beat = 0;
                            m_occ--;
                            m_frame_cnt = (m_frame_cnt + 1) % 65536;
                        end else begin
                            prev_mid = 1;
                        end
                    end else begin
                        prev_stall = 1;
                    end
                end
            end
            if (din_valid) begin
                if (m_idx == 0) begin
                    m_drop = (m_occ == 2);
                    if (m_drop) begin
                        m_ovf = 1;
                        if (m_drop_cnt < 255) m_drop_cnt++;
                    end
                end
                if (!m_drop) cur_frame[m_idx] = {din_re, din_im};
                if (m_idx == N - 1) begin
                    if (!m_drop) begin
                        for (int i = 0; i < N; i++) exp_q.push_back(cur_frame[i]);
                        m_occ++;
                        if (lat_req != lat_seen) begin
                            lat_seen = lat_req;
                            lat_c63  = cyc;
                            lat_wait = 1;
                        end
                    end
                    m_idx = 0;
                end else begin
                    m_idx++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drive_sample(input logic [W-1:0] re, input logic [W-1:0] im);
        din_re = re;
        din_im = im;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
    endtask

    // kind 0: re=k, im=-k; kind 1: random. gap<0: random 0..2 idle cycles.
    task automatic send_frame(input int kind, input int gap, input int nsamp);
        for (int k = 0; k < nsamp; k++) begin
            int g;
            g = (gap < 0) ? $urandom_range(0, 2) : gap;
            repeat (g) step();
            if (kind == 0) drive_sample(W'(k), W'(-k));
            else           drive_sample(W'($urandom), W'($urandom));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        din_valid = 1'b0;
        repeat (2) step();
        chk("rst_valid", dout_valid, 0);
        chk("rst_sof", dout_sof, 0);
        chk("rst_eof", dout_eof, 0);
        chk("rst_index", dout_index, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        rst = 1'b0;
        step();
    endtask

    task automatic wait_drain();
        bit done;
        done = 0;
        for (int t = 0; t < 3000; t++) begin
            step();
            if (exp_q.size() == 0 && m_occ == 0 && !dout_valid) begin
                done = 1;
                break;
            end
        end
        chk("drain_done", done, 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit seen;
        do_reset();

        // Single ramp frame, ready held high, latency measured from sample 63
        ready_mode = 0; ready_const = 1;
        lat_req++;
        send_frame(0, 0, N);
        wait_drain();
        chk("t1_frame_cnt", frame_cnt, 1);
        chk("t1_latency_done", lat_wait, 0);

        // Backpressure pattern 1,0,0,1
        ready_mode = 1;
        send_frame(1, 0, N);
        wait_drain();
        chk("t2_frame_cnt", frame_cnt, 2);
        ready_mode = 0;

        // Three back-to-back frames with no ready: third is dropped
        do_reset();
        ready_const = 0;
        send_frame(0, 0, N);
        send_frame(1, 0, N);
        send_frame(1, 0, N);
        step();
        chk("t3_overflow", overflow, 1);
        chk("t3_drop_cnt", drop_cnt, 1);
        chk("t3_frame_cnt_hold", frame_cnt, 0);
        ready_const = 1;
        wait_drain();
        chk("t3_frame_cnt", frame_cnt, 2);

        // Release of bank 0 on the same edge as the next frame's sample 0
        do_reset();
        ready_const = 0;
        send_frame(1, 0, N);
        send_frame(1, 0, N);
        repeat (3) step();
        ready_const = 1;
        seen = 0;
        for (int t = 0; t < 400; t++) begin
            step();
            if (dout_valid && dout_eof) begin
                seen = 1;
                break;
            end
        end
        chk("t4_eof_seen", seen, 1);
        send_frame(0, 0, N);
        wait_drain();
        chk("t4_overflow", overflow, 0);
        chk("t4_drop_cnt", drop_cnt, 0);
        chk("t4_frame_cnt", frame_cnt, 3);

        // Reset mid-frame with both banks full
        do_reset();
        ready_const = 0;
        send_frame(1, 0, N);
        send_frame(1, 0, N);
        send_frame(1, 0, 30);
        do_reset();
        ready_const = 1;
        send_frame(0, 0, N);
        wait_drain();
        chk("t5_frame_cnt", frame_cnt, 1);
        chk("t5_overflow", overflow, 0);

        // Gapped input: one sample every third cycle
        do_reset();
        ready_const = 1;
        lat_req++;
        send_frame(0, 2, N);
        wait_drain();
        chk("t6_frame_cnt", frame_cnt, 1);
        chk("t6_latency_done", lat_wait, 0);

        // Random data, random gaps, random ready
        ready_mode = 2;
        for (int f = 0; f < 8; f++) send_frame(1, (f % 2) ? -1 : 0, N);
        wait_drain();
        ready_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
